// File: rtl/color_mixer_pkg.sv
// Shared colour definitions: mix modes and the normalise/saturate helper
// used by the mixer and the blender.
package color_mixer_pkg;

  typedef enum logic [1:0] {
    MIX_ADD        = 2'd0,
    MIX_SUB        = 2'd1,
    MIX_MUL        = 2'd2,
    MIX_ADD_SIGNED = 2'd3
  } mix_mode_t;

  localparam int MAX_W = 12;
  localparam int MAX_S = 2 * MAX_W + 2;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] value;
  } norm_t;

  // T = (s + 2^w-1) >>> w, clamped to [0, 2^w-1]; callers sign-extend s to MAX_S.
  function automatic norm_t normalise_sat(input logic signed [MAX_S-1:0] s,
                                          input int w);
    logic signed [MAX_S:0] max_v;
    logic signed [MAX_S:0] biased;
    logic signed [MAX_S:0] t;
    norm_t                 r;
    max_v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      max_v[i] = (i < w);
    end
    biased = {s[MAX_S-1], s} + max_v;
    t      = biased >>> w;
    r.sat   = 1'b0;
    r.value = t[MAX_W-1:0];
    if (t[MAX_S]) begin
      r.sat   = 1'b1;
      r.value = '0;
    end else if (t > max_v) begin
      r.sat   = 1'b1;
      r.value = max_v[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/color_mixer_lane.sv
// One colour channel of the mixer: operand capture, products, mode sum,
// then normalise/saturate. All stages advance together on ce.
module color_mixer_lane
  import color_mixer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  mix_mode_t    mode,
  output logic [W-1:0] result,
  output logic         sat
);

  localparam logic [2*W+1:0] HALF = {2'b00, 1'b1, {(2*W-1){1'b0}}};

  logic [W-1:0]          a_q, b_q, c_q, d_q;
  mix_mode_t             mode_q0, mode_q1;
  logic [2*W-1:0]        ab_q, cd_q;
  logic signed [2*W+1:0] s_q;
  logic signed [2*W+1:0] s_next;
  logic signed [2*W+1:0] ab_s, cd_s;
  logic signed [MAX_S-1:0] s_ext;
  norm_t                 norm;
  logic                  unused_norm;

  // Data-path registers carry no reset; only the visible outputs are cleared.
  always_ff @(posedge aclk) begin
    if (ce) begin
      a_q     <= a;
      b_q     <= b;
      c_q     <= c;
      d_q     <= d;
      mode_q0 <= mode;
      ab_q    <= (2*W)'(a_q) * (2*W)'(b_q);
      cd_q    <= (2*W)'(c_q) * (2*W)'(d_q);
      mode_q1 <= mode_q0;
      s_q     <= s_next;
    end
  end

  always_comb begin
    ab_s   = signed'({2'b00, ab_q});
    cd_s   = signed'({2'b00, cd_q});
    s_next = ab_s;
    case (mode_q1)
      MIX_ADD:        s_next = ab_s + cd_s;
      MIX_SUB:        s_next = ab_s - cd_s;
      MIX_MUL:        s_next = ab_s;
      MIX_ADD_SIGNED: s_next = ab_s + cd_s - signed'(HALF);
      default:        s_next = ab_s;
    endcase
  end

  assign s_ext       = MAX_S'(s_q);
  assign norm        = normalise_sat(s_ext, W);
  assign unused_norm = ^norm.value;

  always_ff @(posedge aclk) begin
    if (reset) begin
      result <= '0;
      sat    <= 1'b0;
    end else if (ce) begin
      result <= norm.value[W-1:0];
      sat    <= norm.sat;
    end
  end

endmodule

// File: rtl/color_mixer_pipe.sv
// Handshaked colour combiner: N lanes of A*B +/- C*D with normalisation,
// a shared advance enable, and the valid/user pipeline alongside.
module color_mixer_pipe
  import color_mixer_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH      = 8,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int USER_WIDTH           = 1
) (
  input  logic                                            aclk,
  input  logic                                            reset,
  input  logic                                            s_valid,
  output logic                                            s_ready,
  input  logic [1:0]                                      s_mode,
  input  logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] s_color_a,
  input  logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] s_color_b,
  input  logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] s_color_c,
  input  logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] s_color_d,
  input  logic [USER_WIDTH-1:0]                           s_user,
  output logic                                            m_valid,
  input  logic                                            m_ready,
  output logic [SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] m_color,
  output logic [NUMBER_OF_SUB_PIXELS-1:0]                 m_sat,
  output logic [USER_WIDTH-1:0]                           m_user
);

  localparam int W = SUB_PIXEL_WIDTH;
  localparam int N = NUMBER_OF_SUB_PIXELS;

  // Handshake: a beat transfers on any rising edge where valid && ready.
  // One enable advances every stage at once, so a stalled output freezes
  // the whole pipe and bubbles are carried rather than squeezed out.
  logic ce;
  assign ce      = m_ready || !m_valid;
  assign s_ready = ce;

  logic                  v0, v1, v2;
  logic [USER_WIDTH-1:0] u0, u1, u2;

  always_ff @(posedge aclk) begin
    if (reset) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_valid <= 1'b0;
      m_user  <= '0;
    end else if (ce) begin
      v0      <= s_valid;
      v1      <= v0;
      v2      <= v1;
      m_valid <= v2;
      m_user  <= u2;
    end
  end

  always_ff @(posedge aclk) begin
    if (ce) begin
      u0 <= s_user;
      u1 <= u0;
      u2 <= u1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    color_mixer_lane #(.W(W)) u_lane (
      .aclk   (aclk),
      .reset  (reset),
      .ce     (ce),
      .a      (s_color_a[i*W +: W]),
      .b      (s_color_b[i*W +: W]),
      .c      (s_color_c[i*W +: W]),
      .d      (s_color_d[i*W +: W]),
      .mode   (mix_mode_t'(s_mode)),
      .result (m_color[i*W +: W]),
      .sat    (m_sat[i])
    );
  end

endmodule

// File: tb/tb_color_mixer_pipe.sv
// Directed bench for color_mixer_pipe at W=8, N=4: vector table, interleaved
// modes, randomised backpressure stream and reset with beats in flight.
module tb_color_mixer_pipe;
  import color_mixer_pkg::*;

  logic        aclk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_mode;
  logic [31:0] s_color_a, s_color_b, s_color_c, s_color_d;
  logic [3:0]  s_user;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_color;
  logic [3:0]  m_sat;
  logic [3:0]  m_user;

  color_mixer_pipe #(
    .SUB_PIXEL_WIDTH(8), .NUMBER_OF_SUB_PIXELS(4), .USER_WIDTH(4)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
    .s_color_a(s_color_a), .s_color_b(s_color_b),
    .s_color_c(s_color_c), .s_color_d(s_color_d), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_color(m_color),
    .m_sat(m_sat), .m_user(m_user)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] color;
    logic [3:0]  sat;
    logic [3:0]  user;
    int          acc;
    bit          chk_lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    mix_mode_t   mode;
    logic [31:0] a, b, c, d;
    logic [31:0] color;
    logic [3:0]  sat;
  } vec_t;
  vec_t vecs[10];

  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference arithmetic for one pixel, written from the channel equations.
  function automatic logic [35:0] model(input mix_mode_t m, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
    logic [31:0] col;
    logic [3:0]  st;
    col = '0;
    st  = '0;
    for (int ch = 0; ch < 4; ch++) begin
      int ab, cd, s, t;
      ab = int'(a[8*ch +: 8]) * int'(b[8*ch +: 8]);
      cd = int'(c[8*ch +: 8]) * int'(d[8*ch +: 8]);
      case (m)
        MIX_ADD:  s = ab + cd;
        MIX_SUB:  s = ab - cd;
        MIX_MUL:  s = ab;
        default:  s = ab + cd - 32768;
      endcase
      t = (s + 255) >>> 8;
      if (t < 0) begin
        st[ch] = 1'b1;
      end else if (t > 255) begin
        st[ch] = 1'b1;
        col[8*ch +: 8] = 8'hFF;
      end else begin
        col[8*ch +: 8] = t[7:0];
      end
    end
    return {st, col};
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input mix_mode_t mode, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d, input logic [3:0] user,
                      input logic [31:0] ecol, input logic [3:0] esat,
                      input bit expect_out, input bit chk_lat);
    int budget = 0;
    bit done = 1'b0;
    s_valid = 1'b1; s_mode = mode; s_user = user;
    s_color_a = a; s_color_b = b; s_color_c = c; s_color_d = d;
    while (!done) begin
      @(negedge aclk);
      if (s_ready) begin
        if (expect_out) exp_q.push_back('{ecol, esat, user, cyc + 1, chk_lat});
        done = 1'b1;
      end else if (++budget > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: s_ready stuck at 0 for %0d cycles, expected 1", budget);
        done = 1'b1;
      end
      @(posedge aclk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge aclk); b++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge aclk); #1;
  endtask

  always @(posedge aclk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: handshake rule, stall stability and scoreboard.
  logic        prev_stall = 1'b0;
  logic [40:0] held;
  always @(negedge aclk) begin
    chk("s_ready_rule", 64'(s_ready), 64'(m_ready || !m_valid));
    if (prev_stall) chk("stall_stable", {23'd0, m_valid, m_color, m_sat, m_user}, {23'd0, held});
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got color %0h user %0h, expected no beat", m_color, m_user);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("m_color", 64'(m_color), 64'(e.color));
        chk("m_sat", 64'(m_sat), 64'(e.sat));
        chk("m_user", 64'(m_user), 64'(e.user));
        if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'd3);
      end
    end
    prev_stall = !reset && m_valid && !m_ready;
    held       = {m_valid, m_color, m_sat, m_user};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{MIX_ADD,        32'hFFFFFFFF, 32'h80808080, 32'h0,        32'h0,        32'h80808080, 4'h0};
    vecs[1] = '{MIX_ADD,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF};
    vecs[2] = '{MIX_SUB,        32'h40404040, 32'h40404040, 32'h80808080, 32'h80808080, 32'h00000000, 4'hF};
    vecs[3] = '{MIX_SUB,        32'h80808080, 32'h80808080, 32'h40404040, 32'h40404040, 32'h30303030, 4'h0};
    vecs[4] = '{MIX_ADD_SIGNED, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h7F7F7F7F, 4'h0};
    vecs[5] = '{MIX_MUL,        32'hFFFFFFFF, 32'h80808080, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80808080, 4'h0};
    vecs[6] = '{MIX_ADD_SIGNED, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h7F7F7F7F, 4'h0};
    vecs[7] = '{MIX_MUL,        32'h10101010, 32'h10101010, 32'h12345678, 32'h9ABCDEF0, 32'h01010101, 4'h0};
    vecs[8] = '{MIX_ADD_SIGNED, 32'h0,        32'h0,        32'h0,        32'h0,        32'h00000000, 4'hF};
    vecs[9] = '{MIX_MUL,        32'h00FF80FF, 32'hFFFF0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00FF0101, 4'h0};

    reset = 1'b1; s_valid = 1'b0; s_mode = 2'd0; s_user = '0; m_ready = 1'b1;
    s_color_a = '0; s_color_b = '0; s_color_c = '0; s_color_d = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_color", 64'(m_color), 64'd0);
    chk("reset_m_sat", 64'(m_sat), 64'd0);
    chk("reset_m_user", 64'(m_user), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    @(posedge aclk); #1;
    reset = 1'b0;

    // Back-to-back table beats, mode changing every beat.
    for (int i = 0; i < 10; i++)
      send(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 4'(i),
           vecs[i].color, vecs[i].sat, 1'b1, 1'b1);
    drain();

    // Stream under random backpressure with model-derived expectations.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mix_mode_t   m;
      logic [31:0] a, b, c, d;
      logic [35:0] r;
      m = mix_mode_t'($urandom_range(0, 3));
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      r = model(m, a, b, c, d);
      send(m, a, b, c, d, 4'(i), r[31:0], r[35:32], 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk); #1;
      end
    end
    drain();
    rand_ready = 1'b0;
    @(posedge aclk); #2;
    m_ready = 1'b1;
    drain();

    // Three beats in flight under stall, then reset: none may emerge.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(MIX_ADD, 32'hFFFFFFFF, 32'h80808080, 32'h0, 32'h0, 4'(9 + i),
           32'h80808080, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    chk("midreset_m_valid", 64'(m_valid), 64'd0);
    chk("midreset_m_color", 64'(m_color), 64'd0);
    chk("midreset_m_sat", 64'(m_sat), 64'd0);
    chk("midreset_m_user", 64'(m_user), 64'd0);
    chk("midreset_s_ready", 64'(s_ready), 64'd1);
    @(posedge aclk); #1;
    m_ready = 1'b1;
    reset = 1'b0;
    repeat (8) @(posedge aclk);
    #1;
    send(MIX_SUB, 32'h80808080, 32'h80808080, 32'h40404040, 32'h40404040, 4'h5,
         32'h30303030, 4'h0, 1'b1, 1'b1);
    drain();
    repeat (5) @(posedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
